// File: rtl/fb_pkg.sv
// Shared types and widths for the framebuffer rectangle-fill initiator.
package fb_pkg;

  localparam int unsigned FB_ADDR_W = 24;
  localparam int unsigned FB_DATA_W = 16;

  typedef logic [FB_DATA_W-1:0] pixel_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP,
    DONE
  } fill_state_t;

endpackage

// File: rtl/fb_rect_fill_if.sv
// Framebuffer access port: write request from the initiator, ack from the responder.
interface fb_rect_fill_if;
  import fb_pkg::*;

  logic     sel_o;
  logic     wr_o;
  logic [3:0] mask_o;
  fb_addr_t address_o;
  pixel_t   data_o;
  logic     ack_i;

  modport master (
    output sel_o,
    output wr_o,
    output mask_o,
    output address_o,
    output data_o,
    input  ack_i
  );

  modport slave (
    input  sel_o,
    input  wr_o,
    input  mask_o,
    input  address_o,
    input  data_o,
    output ack_i
  );

endinterface

// File: rtl/fb_rect_addr_gen.sv
// Clips the rectangle to the framebuffer and walks its pixel addresses row-major.
// row_addr holds the address of the first pixel of the current row (x offset included),
// so moving to the next row is a single add of the row stride.
module fb_rect_addr_gen
  import fb_pkg::*;
#(
  parameter int unsigned FB_WIDTH  = 640,
  parameter int unsigned FB_HEIGHT = 480,
  parameter int unsigned COORD_W   =
    $clog2((FB_WIDTH > FB_HEIGHT ? FB_WIDTH : FB_HEIGHT) + 1)
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               load,
  input  logic               step,
  input  fb_addr_t           base_address,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] width,
  input  logic [COORD_W-1:0] height,
  output logic               last,
  output logic               empty,
  output fb_addr_t           address
);

  localparam logic [COORD_W-1:0] WidthC     = COORD_W'(FB_WIDTH);
  localparam logic [COORD_W-1:0] HeightC    = COORD_W'(FB_HEIGHT);
  localparam fb_addr_t           RowStride  = fb_addr_t'(FB_WIDTH);

  logic [COORD_W-1:0] eff_w_d, eff_h_d;
  logic [COORD_W-1:0] eff_w_q, eff_h_q;
  logic [COORD_W-1:0] x_cnt_q, y_cnt_q;
  fb_addr_t           row_start;
  fb_addr_t           row_addr_q, addr_q;
  logic               row_end;

  // Clip size against the framebuffer edges; an origin outside gives zero size.
  always_comb begin
    eff_w_d = '0;
    eff_h_d = '0;
    if (x < WidthC) begin
      eff_w_d = (width > WidthC - x) ? WidthC - x : width;
    end
    if (y < HeightC) begin
      eff_h_d = (height > HeightC - y) ? HeightC - y : height;
    end
  end

  // Single constant multiply, used only in the load cycle.
  assign row_start = base_address + fb_addr_t'(y) * RowStride + fb_addr_t'(x);

  assign row_end = (x_cnt_q == eff_w_q - COORD_W'(1));
  assign last    = row_end && (y_cnt_q == eff_h_q - COORD_W'(1));
  assign empty   = (eff_w_q == '0) || (eff_h_q == '0);
  assign address = addr_q;

  // Counters and address registers: load at command start, advance one pixel per step.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      eff_w_q    <= '0;
      eff_h_q    <= '0;
      x_cnt_q    <= '0;
      y_cnt_q    <= '0;
      row_addr_q <= '0;
      addr_q     <= '0;
    end else if (load) begin
      eff_w_q    <= eff_w_d;
      eff_h_q    <= eff_h_d;
      x_cnt_q    <= '0;
      y_cnt_q    <= '0;
      row_addr_q <= row_start;
      addr_q     <= row_start;
    end else if (step) begin
      if (row_end) begin
        x_cnt_q    <= '0;
        y_cnt_q    <= y_cnt_q + COORD_W'(1);
        row_addr_q <= row_addr_q + RowStride;
        addr_q     <= row_addr_q + RowStride;
      end else begin
        x_cnt_q <= x_cnt_q + COORD_W'(1);
        addr_q  <= addr_q + fb_addr_t'(1);
      end
    end
  end

endmodule

// File: rtl/fb_rect_fill.sv
// Solid rectangle fill: one framebuffer write per pixel, with early abort.
// A start spends one cycle (load_q) in IDLE while the address generator settles,
// so busy_o rises one cycle before the first request.
module fb_rect_fill
  import fb_pkg::*;
#(
  parameter int unsigned FB_WIDTH  = 640,
  parameter int unsigned FB_HEIGHT = 480,
  parameter int unsigned COORD_W   =
    $clog2((FB_WIDTH > FB_HEIGHT ? FB_WIDTH : FB_HEIGHT) + 1)
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  fb_addr_t           base_address_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [COORD_W-1:0] width_i,
  input  logic [COORD_W-1:0] height_i,
  input  pixel_t             color_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               aborted_o,
  fb_rect_fill_if.master     bus
);

  fill_state_t state_q, state_d;
  logic        load_q, load_d;
  logic        aborted_q, aborted_d;
  pixel_t      color_q;
  logic        accept;
  logic        gen_step, gen_last, gen_empty;
  fb_addr_t    gen_address;

  assign accept = (state_q == IDLE) && !load_q && start_i;

  fb_rect_addr_gen #(
    .FB_WIDTH  (FB_WIDTH),
    .FB_HEIGHT (FB_HEIGHT),
    .COORD_W   (COORD_W)
  ) u_addr_gen (
    .clk          (clk),
    .reset_i      (reset_i),
    .load         (accept),
    .step         (gen_step),
    .base_address (base_address_i),
    .x            (x_i),
    .y            (y_i),
    .width        (width_i),
    .height       (height_i),
    .last         (gen_last),
    .empty        (gen_empty),
    .address      (gen_address)
  );

  // Next state: a granted request always completes before abort is honoured.
  always_comb begin
    state_d   = state_q;
    load_d    = 1'b0;
    aborted_d = aborted_q;
    gen_step  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_q) begin
          state_d = gen_empty ? DONE : REQ;
        end else if (start_i) begin
          load_d    = 1'b1;
          aborted_d = 1'b0;
        end
      end
      REQ: begin
        if (bus.ack_i) begin
          gen_step = 1'b1;
          if (gen_last) begin
            state_d = DONE;
          end else if (abort_i) begin
            state_d   = DONE;
            aborted_d = 1'b1;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (abort_i) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else begin
          state_d = REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, load-cycle flag and abort status registers.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      load_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      load_q    <= load_d;
      aborted_q <= aborted_d;
    end
  end

  // Colour is captured with the rest of the command.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      color_q <= '0;
    end else if (accept) begin
      color_q <= color_i;
    end
  end

  // Moore outputs straight from registers, so reset clears them without waiting for a clock.
  always_comb begin
    busy_o        = load_q || (state_q == REQ) || (state_q == GAP);
    done_o        = (state_q == DONE);
    aborted_o     = aborted_q;
    bus.sel_o     = (state_q == REQ);
    bus.wr_o      = (state_q == REQ);
    bus.mask_o    = 4'hF;
    bus.address_o = gen_address;
    bus.data_o    = color_q;
  end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Bench for fb_rect_fill: directed commands, expected writes/done events queued by the
// stimulus and consumed by a monitor that also plays the acknowledging responder.
module tb_fb_rect_fill;
  import fb_pkg::*;

  localparam int unsigned FBW = 32;
  localparam int unsigned FBH = 24;
  localparam int unsigned CW  = 6;

  typedef struct packed {
    fb_addr_t addr;
    pixel_t   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset_i, start_i, abort_i;
  fb_addr_t      base;
  logic [CW-1:0] x, y, w, h;
  pixel_t        color;
  logic          busy, done, aborted;

  fb_rect_fill_if bus ();

  fb_rect_fill #(
    .FB_WIDTH  (FBW),
    .FB_HEIGHT (FBH),
    .COORD_W   (CW)
  ) dut (
    .clk            (clk),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .base_address_i (base),
    .x_i            (x),
    .y_i            (y),
    .width_i        (w),
    .height_i       (h),
    .color_i        (color),
    .busy_o         (busy),
    .done_o         (done),
    .aborted_o      (aborted),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  wr_t  exp_wr[$];
  logic exp_done[$];
  int   vec = 0;
  int   miss = 0;
  int   ack_delay = 0;
  int   wait_cnt = 0;
  int   writes = 0;
  int   gap_cnt = 0;
  bit   seen_write = 0;
  bit   prev_sel = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_wr(input fb_addr_t a, input pixel_t d);
    exp_wr.push_back('{addr: a, data: d});
  endtask

  // Responder (ack after ack_delay cycles of sel) and monitor, both on the falling edge.
  always @(negedge clk) begin
    if (reset_i) begin
      bus.ack_i  = 1'b0;
      wait_cnt   = 0;
      seen_write = 0;
      gap_cnt    = 0;
      prev_sel   = 0;
    end else begin
      if (bus.sel_o && !bus.ack_i) begin
        if (wait_cnt >= ack_delay) bus.ack_i = 1'b1;
        else wait_cnt++;
      end else begin
        bus.ack_i = 1'b0;
        wait_cnt  = 0;
      end
      if (bus.sel_o) begin
        if (!prev_sel && seen_write) check("gap_cycles", gap_cnt, 1);
        check("wr_eq_sel", {31'd0, bus.wr_o}, 1);
        check("mask", {28'd0, bus.mask_o}, 32'hF);
        if (exp_wr.size() == 0) begin
          vec++;
          miss++;
          $display("FAIL unexpected_write: got address %h, required no request", bus.address_o);
        end else begin
          check("address", {8'd0, bus.address_o}, {8'd0, exp_wr[0].addr});
          check("data", {16'd0, bus.data_o}, {16'd0, exp_wr[0].data});
          if (bus.ack_i) begin
            void'(exp_wr.pop_front());
            writes++;
            seen_write = 1;
          end
        end
        gap_cnt = 0;
      end else begin
        gap_cnt++;
      end
      if (done) begin
        check("busy_at_done", {31'd0, busy}, 0);
        if (exp_done.size() == 0) begin
          vec++;
          miss++;
          $display("FAIL unexpected_done: got done_o=1, required 0");
        end else begin
          check("aborted", {31'd0, aborted}, {31'd0, exp_done.pop_front()});
        end
        seen_write = 0;
      end
      prev_sel = bus.sel_o;
    end
  end

  task automatic issue(input fb_addr_t b, input logic [CW-1:0] xx, input logic [CW-1:0] yy,
                       input logic [CW-1:0] ww, input logic [CW-1:0] hh, input pixel_t c);
    @(posedge clk);
    #1;
    base = b; x = xx; y = yy; w = ww; h = hh; color = c;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    // Scramble the command inputs; the DUT must already have latched them.
    base  = fb_addr_t'($urandom);
    x     = CW'($urandom);
    y     = CW'($urandom);
    w     = CW'($urandom);
    h     = CW'($urandom);
    color = pixel_t'($urandom);
  endtask

  task automatic wait_done(input int max_cycles);
    int n = 0;
    while (!done && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      vec++;
      miss++;
      $display("FAIL done_timeout: got no done_o in %0d cycles, required a pulse", max_cycles);
    end
    #1;
  endtask

  task automatic check_drained(input string name);
    repeat (4) @(posedge clk);
    #1;
    check({name, "_writes_left"}, exp_wr.size(), 0);
    check({name, "_done_left"}, exp_done.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    base = '0; x = '0; y = '0; w = '0; h = '0; color = '0;
    #23;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_sel", {31'd0, bus.sel_o}, 0);
    check("rst_address", {8'd0, bus.address_o}, 0);
    check("rst_data", {16'd0, bus.data_o}, 0);
    check("rst_mask", {28'd0, bus.mask_o}, 32'hF);
    @(posedge clk);
    #1;
    reset_i = 1'b0;

    // 2x2 at origin, immediate ack.
    ack_delay = 0;
    push_wr(24'd0, 16'hBEEF); push_wr(24'd1, 16'hBEEF);
    push_wr(24'd32, 16'hBEEF); push_wr(24'd33, 16'hBEEF);
    exp_done.push_back(1'b0);
    issue(24'd0, 6'd0, 6'd0, 6'd2, 6'd2, 16'hBEEF);
    wait_done(100);
    check_drained("fill2x2");

    // Same fill, ack held off 5 cycles per request.
    ack_delay = 5;
    push_wr(24'd0, 16'hBEEF); push_wr(24'd1, 16'hBEEF);
    push_wr(24'd32, 16'hBEEF); push_wr(24'd33, 16'hBEEF);
    exp_done.push_back(1'b0);
    issue(24'd0, 6'd0, 6'd0, 6'd2, 6'd2, 16'hBEEF);
    wait_done(200);
    check_drained("slow_ack");

    // Zero width: done two cycles after start, no bus request.
    ack_delay = 0;
    exp_done.push_back(1'b0);
    issue(24'h10, 6'd3, 6'd4, 6'd0, 6'd7, 16'h5555);
    check("zero_busy_load", {31'd0, busy}, 1);
    check("zero_done_early", {31'd0, done}, 0);
    @(posedge clk);
    #1;
    check("zero_done_2cyc", {31'd0, done}, 1);
    check_drained("zero_w");

    // Clip both axes: x=30,w=8 -> 2 columns; y=22,h=5 -> 2 rows. 0x1000+22*32+30 = 0x12DE.
    ack_delay = 1;
    push_wr(24'h0012DE, 16'h1234); push_wr(24'h0012DF, 16'h1234);
    push_wr(24'h0012FE, 16'h1234); push_wr(24'h0012FF, 16'h1234);
    exp_done.push_back(1'b0);
    issue(24'h001000, 6'd30, 6'd22, 6'd8, 6'd5, 16'h1234);
    wait_done(200);
    check_drained("clip");

    // Origin off the right edge behaves as zero size.
    exp_done.push_back(1'b0);
    issue(24'h0, 6'd32, 6'd0, 6'd3, 6'd3, 16'h9999);
    wait_done(20);
    check_drained("x_outside");

    // Abort during the third request of a 4x4 at (4,2): 0x200+64+4 = 0x244.
    ack_delay = 3;
    writes = 0;
    push_wr(24'h000244, 16'hA5A5); push_wr(24'h000245, 16'hA5A5);
    push_wr(24'h000246, 16'hA5A5);
    exp_done.push_back(1'b1);
    issue(24'h000200, 6'd4, 6'd2, 6'd4, 6'd4, 16'hA5A5);
    begin
      int n = 0;
      while (!(writes == 2 && bus.sel_o) && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!(writes == 2 && bus.sel_o)) begin
        vec++;
        miss++;
        $display("FAIL abort_setup: got %0d writes, required third request", writes);
      end
    end
    abort_i = 1'b1;
    wait_done(100);
    abort_i = 1'b0;
    check("abort_writes", writes, 3);
    check_drained("abort");

    // Address wrap at the top of the 24-bit space.
    ack_delay = 0;
    push_wr(24'hFFFFFF, 16'h0F0F); push_wr(24'h000000, 16'h0F0F);
    exp_done.push_back(1'b0);
    issue(24'hFFFFFF, 6'd0, 6'd0, 6'd2, 6'd1, 16'h0F0F);
    wait_done(100);
    check_drained("wrap");

    // Back-to-back: start in DONE ignored (B), start in next IDLE accepted (C).
    push_wr(24'h000321, 16'h1111);
    push_wr(24'h000500, 16'h2222);
    exp_done.push_back(1'b0);
    exp_done.push_back(1'b0);
    issue(24'h000300, 6'd1, 6'd1, 6'd1, 6'd1, 16'h1111);
    wait_done(100);
    base = 24'h000400; x = '0; y = '0; w = 6'd1; h = 6'd1; color = 16'hDEAD;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    base = 24'h000500; color = 16'h2222;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done(100);
    check_drained("back2back");

    // Reset while a request is outstanding.
    ack_delay = 20;
    push_wr(24'h000000, 16'h7777);
    issue(24'h0, 6'd0, 6'd0, 6'd1, 6'd1, 16'h7777);
    begin
      int n = 0;
      while (!bus.sel_o && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    #2;
    reset_i = 1'b1;
    #1;
    check("mid_rst_sel", {31'd0, bus.sel_o}, 0);
    check("mid_rst_wr", {31'd0, bus.wr_o}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_address", {8'd0, bus.address_o}, 0);
    check("mid_rst_data", {16'd0, bus.data_o}, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    exp_wr.delete();
    exp_done.delete();
    ack_delay = 0;
    push_wr(24'h000042, 16'h3C3C); push_wr(24'h000062, 16'h3C3C);
    exp_done.push_back(1'b0);
    issue(24'h000040, 6'd2, 6'd0, 6'd1, 6'd2, 16'h3C3C);
    wait_done(100);
    check_drained("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
